// File: rtl/digi_ota_array.sv
// digi_ota_array
// Array of CHANNELS independent digital transconductance channels. Each channel
// synchronises a differential pair of comparator bits, turns it into an
// UP/DN/HOLD decision, integrates that decision into a saturating accumulator,
// and compares the accumulator with a shared ramp to form a PWM output. A
// per-channel hold timer keeps the pad driver enabled for HOLD cycles after the
// last non-zero decision.
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset (release synchronous to clk)
//   ena       global enable; low freezes acc, ramp, tmr, out and sat, clears out_oe
//   vip, vin  per-channel asynchronous comparator inputs
//   gain_sel  shared integrator step select, step = 1 << gain_sel
//   out       per-channel PWM output (registered acc > ramp)
//   out_oe    per-channel drive enable (registered tmr != 0 && ena)
//   sat       per-channel flag, integrator sitting on either rail
module digi_ota_array #(
    parameter int CHANNELS    = 2,
    parameter int ACC_W       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [CHANNELS-1:0] vip,
    input  logic [CHANNELS-1:0] vin,
    input  logic [1:0]          gain_sel,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] out_oe,
    output logic [CHANNELS-1:0] sat
);

    localparam logic [ACC_W-1:0] ACC_MID = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
    localparam logic [7:0]       HOLD_LD = 8'(HOLD);

    // Index SYNC_STAGES-1 is the oldest (fully synchronised) sample.
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_vip_sync;
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_vin_sync;

    logic [CHANNELS-1:0][ACC_W-1:0] r_acc;
    logic [CHANNELS-1:0][7:0]       r_tmr;
    logic [ACC_W-1:0]               r_ramp;
    logic [CHANNELS-1:0]            r_out;
    logic [CHANNELS-1:0]            r_oe;
    logic [CHANNELS-1:0]            r_sat;

    logic [CHANNELS-1:0] w_vip;
    logic [CHANNELS-1:0] w_vin;
    logic [CHANNELS-1:0] w_up;
    logic [CHANNELS-1:0] w_dn;
    logic [ACC_W:0]      w_step;

    // One integration step computed one bit wider than the accumulator so that
    // both overflow (carry) and underflow (borrow) are visible in the MSB and
    // the result can be clamped to the rail instead of wrapping.
    function automatic logic [ACC_W-1:0] f_integrate(
        input logic [ACC_W-1:0] acc,
        input logic             up,
        input logic             dn,
        input logic [ACC_W:0]   step
    );
        logic [ACC_W:0] ext;
        ext = {1'b0, acc};
        if (up) begin
            ext = ext + step;
            return ext[ACC_W] ? ACC_MAX : ext[ACC_W-1:0];
        end else if (dn) begin
            ext = ext - step;
            return ext[ACC_W] ? '0 : ext[ACC_W-1:0];
        end
        return acc;
    endfunction

    // Synchronisers run regardless of ena so the decision is always current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vip_sync <= '0;
            r_vin_sync <= '0;
        end else begin
            r_vip_sync <= {r_vip_sync[SYNC_STAGES-2:0], vip};
            r_vin_sync <= {r_vin_sync[SYNC_STAGES-2:0], vin};
        end
    end

    assign w_vip  = r_vip_sync[SYNC_STAGES-1];
    assign w_vin  = r_vin_sync[SYNC_STAGES-1];
    assign w_up   = w_vip & ~w_vin;
    assign w_dn   = ~w_vip & w_vin;
    assign w_step = (ACC_W+1)'(1) << gain_sel;

    // Integrator, hold timer and shared ramp: all frozen while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= {CHANNELS{ACC_MID}};
            r_tmr  <= '0;
            r_ramp <= '0;
        end else if (ena) begin
            r_ramp <= r_ramp + 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= f_integrate(r_acc[i], w_up[i], w_dn[i], w_step);
                if (w_up[i] || w_dn[i]) begin
                    r_tmr[i] <= HOLD_LD;
                end else if (r_tmr[i] != 8'd0) begin
                    r_tmr[i] <= r_tmr[i] - 8'd1;
                end
            end
        end
    end

    // Output stage: out and sat hold while disabled; out_oe drops the cycle
    // after ena falls and comes back as soon as ena returns with tmr non-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
            r_oe  <= '0;
            r_sat <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_oe[i] <= (r_tmr[i] != 8'd0) && ena;
                if (ena) begin
                    r_out[i] <= (r_acc[i] > r_ramp);
                    r_sat[i] <= (r_acc[i] == '0) || (r_acc[i] == ACC_MAX);
                end
            end
        end
    end

    assign out    = r_out;
    assign out_oe = r_oe;
    assign sat    = r_sat;

endmodule

// File: tb/tb_digi_ota_array.sv
// Testbench for digi_ota_array (CHANNELS=2, ACC_W=6, SYNC_STAGES=2, HOLD=4).
// A vector table drives the integrate/saturate/hold/PWM behaviour; hand-written
// sequences cover the single-cycle pulse, ena freeze and asynchronous reset.
module tb_digi_ota_array;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [1:0] vip;
    logic [1:0] vin;
    logic [1:0] gain_sel;
    logic [1:0] out;
    logic [1:0] out_oe;
    logic [1:0] sat;

    int n_checks = 0;
    int n_err    = 0;

    digi_ota_array #(
        .CHANNELS   (2),
        .ACC_W      (6),
        .SYNC_STAGES(2),
        .HOLD       (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .vip     (vip),
        .vin     (vin),
        .gain_sel(gain_sel),
        .out     (out),
        .out_oe  (out_oe),
        .sat     (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ramp: counts enabled clock edges since reset.
    logic [5:0] ramp_m;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ramp_m <= '0;
        else if (ena) ramp_m <= ramp_m + 6'd1;
    end

    typedef struct {
        logic [1:0] vip;
        logic [1:0] vin;
        logic [1:0] gain;
        int         n;
        logic [5:0] acc0;
        logic [5:0] acc1;
        logic [1:0] sat;
        logic [1:0] oe;
        int         cnt0;
        int         cnt1;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        int c1;
        // vip, vin, gain, ticks, acc0, acc1, sat, oe, out0 count, out1 count (-1 = skip)
        tbl[0]  = '{2'b01, 2'b00, 2'd0,  1, 6'd32, 6'd32, 2'b00, 2'b00, -1, -1};
        tbl[1]  = '{2'b01, 2'b00, 2'd0,  1, 6'd32, 6'd32, 2'b00, 2'b00, -1, -1};
        tbl[2]  = '{2'b01, 2'b00, 2'd0,  1, 6'd33, 6'd32, 2'b00, 2'b00, -1, -1};
        tbl[3]  = '{2'b01, 2'b00, 2'd0,  1, 6'd34, 6'd32, 2'b00, 2'b01, -1, -1};
        tbl[4]  = '{2'b01, 2'b00, 2'd0, 29, 6'd63, 6'd32, 2'b00, 2'b01, -1, -1};
        tbl[5]  = '{2'b01, 2'b00, 2'd0,  1, 6'd63, 6'd32, 2'b01, 2'b01, -1, -1};
        tbl[6]  = '{2'b01, 2'b00, 2'd0,  3, 6'd63, 6'd32, 2'b01, 2'b01, -1, -1};
        tbl[7]  = '{2'b00, 2'b10, 2'd3,  2, 6'd63, 6'd32, 2'b01, 2'b01, -1, -1};
        tbl[8]  = '{2'b00, 2'b10, 2'd3,  1, 6'd63, 6'd24, 2'b01, 2'b01, -1, -1};
        tbl[9]  = '{2'b00, 2'b10, 2'd3,  1, 6'd63, 6'd16, 2'b01, 2'b11, -1, -1};
        tbl[10] = '{2'b00, 2'b10, 2'd3,  1, 6'd63, 6'd8,  2'b01, 2'b11, -1, -1};
        tbl[11] = '{2'b00, 2'b10, 2'd3,  1, 6'd63, 6'd0,  2'b01, 2'b11, -1, -1};
        tbl[12] = '{2'b00, 2'b10, 2'd3,  1, 6'd63, 6'd0,  2'b11, 2'b10, -1, -1};
        tbl[13] = '{2'b00, 2'b10, 2'd3,  8, 6'd63, 6'd0,  2'b11, 2'b10, -1,  0};
        tbl[14] = '{2'b10, 2'b00, 2'd3,  2, 6'd63, 6'd0,  2'b11, 2'b10, -1, -1};
        tbl[15] = '{2'b11, 2'b11, 2'd3,  2, 6'd63, 6'd16, 2'b01, 2'b10, -1, -1};
        tbl[16] = '{2'b11, 2'b11, 2'd3,  1, 6'd63, 6'd16, 2'b01, 2'b10, -1, -1};
        tbl[17] = '{2'b11, 2'b11, 2'd3,  3, 6'd63, 6'd16, 2'b01, 2'b10, -1, -1};
        tbl[18] = '{2'b11, 2'b11, 2'd3,  1, 6'd63, 6'd16, 2'b01, 2'b00, -1, -1};
        tbl[19] = '{2'b11, 2'b11, 2'd3, 64, 6'd63, 6'd16, 2'b01, 2'b00, 63, 16};

        // Reset
        rst_n    = 1'b0;
        ena      = 1'b1;
        vip      = 2'b00;
        vin      = 2'b00;
        gain_sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_oe", 32'(out_oe), 32'd0);
        chk("reset_sat", 32'(sat), 32'd0);
        chk("reset_acc0", 32'(dut.r_acc[0]), 32'd32);
        chk("reset_acc1", 32'(dut.r_acc[1]), 32'd32);
        chk("reset_ramp", 32'(dut.r_ramp), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven integration, saturation, hold timer and PWM
        for (int r = 0; r < 20; r++) begin
            vip      = tbl[r].vip;
            vin      = tbl[r].vin;
            gain_sel = tbl[r].gain;
            c0 = 0;
            c1 = 0;
            for (int k = 0; k < tbl[r].n; k++) begin
                tick();
                c0 += int'(out[0]);
                c1 += int'(out[1]);
            end
            chk($sformatf("row%0d_acc0", r), 32'(dut.r_acc[0]), 32'(tbl[r].acc0));
            chk($sformatf("row%0d_acc1", r), 32'(dut.r_acc[1]), 32'(tbl[r].acc1));
            chk($sformatf("row%0d_sat", r), 32'(sat), 32'(tbl[r].sat));
            chk($sformatf("row%0d_oe", r), 32'(out_oe), 32'(tbl[r].oe));
            if (tbl[r].cnt0 >= 0) chk($sformatf("row%0d_pwm0", r), 32'(c0), 32'(tbl[r].cnt0));
            if (tbl[r].cnt1 >= 0) chk($sformatf("row%0d_pwm1", r), 32'(c1), 32'(tbl[r].cnt1));
        end

        // One-cycle UP pulse on ch1 at gain 1: oe high for exactly HOLD cycles
        gain_sel = 2'd0;
        vin      = 2'b01;
        c1 = 0;
        tick();
        c1 += int'(out_oe[1]);
        vin = 2'b11;
        repeat (11) begin
            tick();
            c1 += int'(out_oe[1]);
        end
        chk("pulse_oe_cycles", 32'(c1), 32'd4);
        chk("pulse_acc1", 32'(dut.r_acc[1]), 32'd17);
        chk("pulse_oe_end", 32'(out_oe), 32'd0);

        // ena low for 10 cycles with the hold timer running
        vin = 2'b01;
        tick();
        vin = 2'b11;
        repeat (3) tick();
        chk("ena_pre_oe", 32'(out_oe), 32'b10);
        chk("ena_pre_acc1", 32'(dut.r_acc[1]), 32'd18);
        ena = 1'b0;
        repeat (10) tick();
        chk("ena_off_oe", 32'(out_oe), 32'd0);
        chk("ena_off_acc0", 32'(dut.r_acc[0]), 32'd63);
        chk("ena_off_acc1", 32'(dut.r_acc[1]), 32'd18);
        chk("ena_off_sat", 32'(sat), 32'b01);
        chk("ena_off_ramp", 32'(dut.r_ramp), 32'(ramp_m));
        ena = 1'b1;
        tick();
        chk("ena_back_oe", 32'(out_oe), 32'b10);

        // Asynchronous reset in the middle of down-integration on ch0
        vip = 2'b10;
        vin = 2'b11;
        repeat (15) tick();
        chk("pre_rst_acc0", 32'(dut.r_acc[0]), 32'd50);
        chk("pre_rst_oe", 32'(out_oe), 32'b01);
        chk("pre_rst_sat", 32'(sat), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_oe", 32'(out_oe), 32'd0);
        chk("async_rst_sat", 32'(sat), 32'd0);
        chk("async_rst_out", 32'(out), 32'd0);
        chk("async_rst_acc0", 32'(dut.r_acc[0]), 32'd32);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_acc0", 32'(dut.r_acc[0]), 32'd32);
        chk("post_rst_acc1", 32'(dut.r_acc[1]), 32'd32);
        chk("post_rst_ramp", 32'(dut.r_ramp), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/digi_ota_array.md
# digi_ota_array

Clocked, parametrised successor to the gate-level digital OTA: an array of CHANNELS independent digital transconductance channels, each turning a differential pair of 1-bit comparator inputs into a saturating integrator state and a PWM output with a hold-timed output enable. It sits between the analog pin comparators and the pad drivers. It replaces the single asynchronous tristate stage with synchronised, gain-selectable, integrating behaviour.

## Interface
Parameters:
- CHANNELS, 2, number of independent channels
- ACC_W, 6, integrator and ramp width (bits); midpoint MID = 2^(ACC_W-1)
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- HOLD, 4, output-enable hold time in cycles after the last non-zero decision (1..255)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- ena  in  1  global enable; low freezes all state
- vip  in  CHANNELS  per-channel positive comparator input (asynchronous)
- vin  in  CHANNELS  per-channel negative comparator input (asynchronous)
- gain_sel  in  2  integrator step = 1 << gain_sel (1, 2, 4, 8), shared
- out  out  CHANNELS  per-channel PWM output
- out_oe  out  CHANNELS  per-channel drive enable for out
- sat  out  CHANNELS  per-channel integrator-at-rail flag

## Operation
- Synchroniser: vip[i] and vin[i] each pass through SYNC_STAGES flops, reset 0, and are always clocked, ignoring ena.
- Decision per channel, from synchronised values: UP when vip=1 and vin=0; DN when vip=0 and vin=1; HOLD when they are equal.
- Integrator acc[i], ACC_W-bit unsigned, reset MID. When ena=1:
  - UP: acc + step, saturating at 2^ACC_W-1.
  - DN: acc - step, saturating at 0.
  - HOLD: unchanged.
  - Compute with ACC_W+1 bits, then clamp. No wrap-around is permitted.
- Ramp: one shared ACC_W-bit free-running counter, reset 0. It increments when ena=1 and wraps from 2^ACC_W-1 to 0.
- out[i]: registered value of (acc[i] > ramp). Duty cycle is acc/2^ACC_W. acc=0 gives a constant 0. acc=max gives 1 for 2^ACC_W-1 of every 2^ACC_W cycles.
- Hold timer tmr[i], reset 0, updated when ena=1:
  - Reloads to HOLD on an UP or DN decision.
  - Otherwise decrements, saturating at 0.
- out_oe[i]: registered value of (tmr[i] != 0) AND ena. It is therefore forced to 0 the cycle after ena falls.
- sat[i]: registered value of (acc==0 or acc==2^ACC_W-1).
- ena=0: acc, ramp and tmr hold their values. out and sat hold. out_oe goes to 0.
- Channels are fully independent. Only ramp and gain_sel are shared.

## Timing
- Reset values: out=0, out_oe=0, sat=0, acc=MID, ramp=0, tmr=0, synchronisers=0. Reset is applied asynchronously; release is synchronous to clk.
- Latency from an input change sampled at edge k:
  - decision valid after edge k+SYNC_STAGES-1;
  - acc updated at edge k+SYNC_STAGES;
  - out, sat and out_oe reflect it at edge k+SYNC_STAGES+1.
- A gain_sel change applies to the next acc update.
- A saturating step lands exactly on the rail in one cycle, e.g. acc=60, step 8 gives 63.
- Reset asserted mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge.
- A decision that reverses mid-hold reloads tmr to HOLD. oe stays high without a gap.

## Test plan
Conditions for all scenarios: CHANNELS=2, ACC_W=6, SYNC_STAGES=2, HOLD=4, ena=1 unless noted.
- Reset: pulse rst_n low -> acc=32, ramp=0; out, out_oe and sat all 0; first acc change occurs no earlier than 2 edges after an input change.
- Up-integration with gain_sel=0 and ch0 vip=1/vin=0 held -> acc0 goes 33, 34, ... 63 after 31 updates; sat0=1 one cycle later; acc0 stays 63; ch1 stays at 32.
- Down-integration with gain_sel=3 and ch0 vip=0/vin=1 from 32 -> acc0 goes 24, 16, 8, 0 and holds at 0; sat0=1; out0 constant 0.
- PWM: drive acc0 to 16, then set vip=vin=1 -> out0 is high for exactly 16 of every 64 cycles; out_oe0 falls 4 cycles after the last non-zero decision.
- Hold and ena behaviour:
  - a 1-cycle UP pulse gives out_oe high for 4 cycles, then low, with acc +step;
  - ena=0 for 10 cycles gives acc and ramp frozen and out_oe=0;
  - on ena=1, out_oe returns while tmr is non-zero.
- Asynchronous reset mid-integration (acc0=50, out_oe0=1) -> out_oe0=0 and sat0=0 before the next clk edge; acc0=32 after release.
